// File: rtl/peripheral_arbiter_apb4_pkg.sv
// Shared types and constants for the peripheral arbiter: FSM states, slave response codes, watchdog limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peripheral_arbiter_apb4_pkg;

  // One transaction outstanding at a time; the write and read paths share IDLE and DONE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Slave response codes carried on bresp/rresp.
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Watchdog expiry value of the 8-bit per-state cycle counter.
  localparam int TIMEOUT_LIMIT = 255;

  // Both SLVERR and DECERR report an error to the master (bit 1 of the code).
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic e;
    e = 1'b0;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   e = 1'b0;
      RESP_SLVERR, RESP_DECERR: e = 1'b1;
    endcase
    return e;
  endfunction

  // States in which the FSM is waiting on the slave.
  function automatic logic is_wait_state(input state_t st);
    return (st == ST_WADDR) || (st == ST_WRESP) || (st == ST_RADDR) || (st == ST_RDATA);
  endfunction

endpackage

// File: rtl/peripheral_arbiter_apb4_rr.sv
// Round-robin pick: first set request at or above the pointer, wrapping from NM-1 to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module peripheral_rr_arbiter_apb4 #(
  parameter int NM = 2,
  parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [NM-1:0] o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_k;

  // Scan requests starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int i = 0; i < NM; i++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NM)) begin
        w_sum = w_sum - (PW+1)'(NM);
      end
      w_k = w_sum[PW-1:0];
      if (!w_found && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
        w_found    = 1'b1;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/peripheral_arbiter_apb4.sv
// Multi-master to single-slave bridge: round-robin grant, then one write (AW+W+B) or read (AR+R) on the slave.
// Latency: grant one cycle after request; m_done the cycle after the final slave handshake.
// Backpressure: slave valids held until ready; new requests ignored until back in IDLE. Optional watchdog: PERIPHERAL_ARBITER_TIMEOUT_EN.
module peripheral_arbiter_apb4
  import peripheral_arbiter_apb4_pkg::*;
#(
  parameter int NM = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_we,
  input  logic [NM-1:0][31:0]  m_addr,
  input  logic [NM-1:0][31:0]  m_wdata,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_done,
  output logic [31:0]          m_rdata,
  output logic                 m_err,
  output logic [31:0]          awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wrdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [31:0]          araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [NM-1:0] r_gnt;
  logic [PW-1:0] r_gidx;
  logic [PW-1:0] r_ptr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          r_aw_done;
  logic          r_w_done;

  logic [NM-1:0] w_sel_gnt;
  logic [PW-1:0] w_sel_idx;
  logic          w_any;
  logic          w_aw_fire;
  logic          w_w_fire;
  logic          w_timeout;
  logic          w_to_fire;

  peripheral_rr_arbiter_apb4 #(
    .NM (NM),
    .PW (PW)
  ) u_rr (
    .i_req (m_req),
    .i_ptr (r_ptr),
    .o_gnt (w_sel_gnt),
    .o_idx (w_sel_idx),
    .o_any (w_any)
  );

`ifdef PERIPHERAL_ARBITER_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Per-state cycle counter: zero on every state entry, counts only while waiting on the slave.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (is_wait_state(r_state)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Expires on the cycle the counter would reach the limit, so the stall lasts exactly TIMEOUT_LIMIT cycles.
  assign w_timeout = is_wait_state(r_state) && (r_cnt == 8'(TIMEOUT_LIMIT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and slave/master handshake outputs, decoded from the registered state.
  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    m_done    = '0;
    w_aw_fire = 1'b0;
    w_w_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next = m_we[w_sel_idx] ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        // Address and data channels retire independently; move on only once both are done.
        awvalid   = !r_aw_done;
        wvalid    = !r_w_done;
        w_aw_fire = awvalid && awready;
        w_w_fire  = wvalid && wready;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
          w_next = ST_WRESP;
        end
      end
      ST_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          w_next = ST_DONE;
        end
      end
      ST_RADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_next = ST_RDATA;
        end
      end
      ST_RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        m_done = r_gnt;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // A real handshake that advances the FSM in the expiry cycle takes precedence over the watchdog.
    if (w_timeout && (w_next == r_state)) begin
      w_next    = ST_DONE;
      w_to_fire = 1'b1;
    end
  end

  // Transaction context: grant, latched request, response capture and pointer advance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_gnt     <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_sel_gnt;
            r_gidx    <= w_sel_idx;
            r_addr    <= m_addr[w_sel_idx];
            r_wdata   <= m_wdata[w_sel_idx];
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        ST_WADDR: begin
          if (w_aw_fire) begin
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_w_done <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            r_err <= resp_is_err(bresp);
          end
        end
        ST_RDATA: begin
          if (rvalid) begin
            r_rdata <= rdata;
            r_err   <= resp_is_err(rresp);
          end
        end
        ST_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_gidx == PW'(NM - 1)) ? '0 : r_gidx + 1'b1;
        end
        default: begin
        end
      endcase
      if (w_to_fire) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign m_gnt   = r_gnt;
  assign m_rdata = r_rdata;
  assign m_err   = r_err;
  assign awaddr  = r_addr;
  assign wrdata  = r_wdata;
  assign araddr  = r_addr;

endmodule

// File: tb/tb_peripheral_arbiter_apb4.sv
// Directed bench for peripheral_arbiter_apb4 with NM=2: write, error read, alternation, split write handshake, mid-read reset.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: slave ready/valid driven by hand per step.
module tb_peripheral_arbiter_apb4;

  logic             aclk;
  logic             aresetn;
  logic [1:0]       m_req;
  logic [1:0]       m_we;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;
  logic [1:0]       m_gnt;
  logic [1:0]       m_done;
  logic [31:0]      m_rdata;
  logic             m_err;
  logic [31:0]      awaddr;
  logic             awvalid;
  logic             awready;
  logic [31:0]      wrdata;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  int n_checks;
  int n_errors;
  int aw_cnt;
  int w_cnt;

  peripheral_arbiter_apb4 #(.NM(2)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_done  (m_done),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wrdata  (wrdata),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Count slave handshakes in the settled cycle, then advance one clock.
  task automatic tick();
    #1;
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready) w_cnt++;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_done(input int budget, output logic [1:0] seen, output int n);
    n = 0;
    seen = '0;
    while (n < budget && seen == 2'b00) begin
      tick();
      n++;
      seen = m_done;
    end
  endtask

  logic [1:0] seen;
  int         ncyc;

  initial begin
    n_checks = 0; n_errors = 0; aw_cnt = 0; w_cnt = 0;
    aresetn = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'd0; rvalid = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_done", 32'(m_done), 32'h0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'h0);
    chk("rst_rdata_err", m_rdata | 32'(m_err), 32'h0);
    chk("rst_addr", awaddr | wrdata | araddr, 32'h0);
    aresetn = 1'b1;

    // m0 write 0x10 <- 0xDEADBEEF, slave ready at once, OKAY response
    m_req = 2'b01; m_we = 2'b01; m_addr[0] = 32'h10; m_wdata[0] = 32'hDEADBEEF;
    awready = 1'b1; wready = 1'b1;
    tick();
    chk("wr_gnt", 32'(m_gnt), 32'h1);
    chk("wr_valids", 32'({awvalid, wvalid}), 32'h3);
    chk("wr_awaddr", awaddr, 32'h10);
    chk("wr_wdata", wrdata, 32'hDEADBEEF);
    m_req = 2'b00;
    tick();
    chk("wr_bready", 32'({awvalid, wvalid, bready}), 32'h1);
    tick();
    chk("wr_nodone_yet", 32'(m_done), 32'h0);
    bvalid = 1'b1; bresp = 2'd0;
    tick();
    chk("wr_done", 32'(m_done), 32'h1);
    chk("wr_err", 32'(m_err), 32'h0);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    chk("wr_idle_gnt", 32'({m_gnt, m_done}), 32'h0);

    // m1 read with SLVERR and rdata 0x1234
    m_req = 2'b10; m_we = 2'b00; m_addr[1] = 32'h40;
    arready = 1'b1; rvalid = 1'b1; rresp = 2'd2; rdata = 32'h1234;
    tick();
    chk("rd_gnt", 32'(m_gnt), 32'h2);
    chk("rd_arvalid", 32'(arvalid), 32'h1);
    chk("rd_araddr", araddr, 32'h40);
    tick();
    chk("rd_rready", 32'({arvalid, rready}), 32'h1);
    tick();
    chk("rd_done", 32'(m_done), 32'h2);
    chk("rd_err", 32'(m_err), 32'h1);
    chk("rd_rdata", m_rdata, 32'h1234);
    m_req = 2'b00;
    tick();
    chk("rd_idle_gnt", 32'(m_gnt), 32'h0);

    // Both masters reading continuously: grants alternate starting at m0
    m_req = 2'b11; m_we = 2'b00; m_addr[0] = 32'h100; m_addr[1] = 32'h200; rresp = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rdata = 32'hA5A5_0000 + 32'(i);
      wait_done(20, seen, ncyc);
      chk("alt_done", 32'(seen), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_rdata", m_rdata, 32'hA5A5_0000 + 32'(i));
      chk("alt_err", 32'(m_err), 32'h0);
      if (i == 3) m_req = 2'b00;
    end
    tick();

    // wready two cycles ahead of awready: one write of each kind reaches the slave
    aw_cnt = 0; w_cnt = 0;
    m_req = 2'b01; m_we = 2'b01; m_addr[0] = 32'h20; m_wdata[0] = 32'hCAFEF00D;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b1;
    tick();
    chk("split_gnt", 32'(m_gnt), 32'h1);
    chk("split_v0", 32'({awvalid, wvalid}), 32'h3);
    tick();
    chk("split_v1", 32'({awvalid, wvalid}), 32'h2);
    tick();
    chk("split_v2", 32'({awvalid, wvalid}), 32'h2);
    awready = 1'b1;
    tick();
    chk("split_wresp", 32'({awvalid, wvalid, bready}), 32'h1);
    chk("split_aw_cnt", 32'(aw_cnt), 32'd1);
    chk("split_w_cnt", 32'(w_cnt), 32'd1);
    bvalid = 1'b1; bresp = 2'd0; awready = 1'b0; wready = 1'b0; m_req = 2'b00;
    tick();
    chk("split_done", 32'(m_done), 32'h1);
    bvalid = 1'b0;
    tick();

    // Reset in RDATA: outputs clear immediately, no done, next grant to m0
    m_req = 2'b10; m_we = 2'b00; m_addr[1] = 32'h80; arready = 1'b1; rvalid = 1'b0;
    tick();
    chk("rst_mid_gnt", 32'(m_gnt), 32'h2);
    tick();
    chk("rst_mid_rready", 32'(rready), 32'h1);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_hs", 32'({rready, arvalid, bready, awvalid, wvalid}), 32'h0);
    chk("rst_mid_gnt0", 32'({m_gnt, m_done, m_err}), 32'h0);
    chk("rst_mid_data", m_rdata | araddr | awaddr | wrdata, 32'h0);
    m_req = 2'b00; rvalid = 1'b1;
    tick();
    chk("rst_mid_nodone0", 32'(m_done), 32'h0);
    tick();
    chk("rst_mid_nodone1", 32'(m_done), 32'h0);
    aresetn = 1'b1;
    m_req = 2'b11;
    tick();
    chk("rst_next_gnt", 32'(m_gnt), 32'h1);
    wait_done(20, seen, ncyc);
    chk("rst_next_done", 32'(seen), 32'h1);
    m_req = 2'b00;
    tick();

`ifdef PERIPHERAL_ARBITER_TIMEOUT_EN
    // Slave never accepts the read address: watchdog ends the transaction with an error
    m_req = 2'b01; m_we = 2'b00; arready = 1'b0; rvalid = 1'b0;
    tick();
    chk("to_gnt", 32'(m_gnt), 32'h1);
    m_req = 2'b00;
    wait_done(300, seen, ncyc);
    chk("to_done", 32'(seen), 32'h1);
    chk("to_cycles", 32'(ncyc), 32'd255);
    chk("to_err", 32'(m_err), 32'h1);
    chk("to_rdata", m_rdata, 32'h0);
    chk("to_arvalid", 32'(arvalid), 32'h0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peripheral_arbiter_apb4.md
PERIPHERAL_ARBITER_APB4 -- requirements
Module: peripheral_arbiter_apb4
Interface
REQ-001 SHALL have parameter NM, default 2, the number of requesting masters (>=2).
REQ-002 SHALL have port aclk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port m_req  input  NM  per-master request, level.
REQ-005 SHALL have port m_we  input  NM  per-master direction: 1 = write, 0 = read.
REQ-006 SHALL have port m_addr  input  NMx32  per-master address.
REQ-007 SHALL have port m_wdata  input  NMx32  per-master write data; full-word writes only.
REQ-008 SHALL have port m_gnt  output  NM  one-hot grant, held from acceptance until done.
REQ-009 SHALL have port m_done  output  NM  one-cycle completion pulse to the granted master.
REQ-010 SHALL have port m_rdata  output  32  read data, valid with m_done.
REQ-011 SHALL have port m_err  output  1  error flag, valid with m_done.
REQ-012 SHALL have ports awaddr (output, 32), awvalid (output, 1) and awready (input, 1): the slave write-address channel.
REQ-013 SHALL have ports wrdata (output, 32), wvalid (output, 1) and wready (input, 1): the slave write-data channel.
REQ-014 SHALL have ports bresp (input, 2), bvalid (input, 1) and bready (output, 1): the slave write-response channel.
REQ-015 SHALL have ports araddr (output, 32), arvalid (output, 1) and arready (input, 1): the slave read-address channel.
REQ-016 SHALL have ports rdata (input, 32), rresp (input, 2), rvalid (input, 1) and rready (output, 1): the slave read-data channel.
Function
REQ-017 SHALL implement FSM states IDLE, WADDR, WRESP, RADDR, RDATA and DONE, one transaction outstanding at a time.
REQ-018 SHALL, in IDLE with any m_req set, grant round-robin starting at pointer ptr.
- Grant goes to the first requester at or above ptr, wrapping from NM-1 to 0.
- The arbiter latches m_we, m_addr and m_wdata into registers.
- m_gnt asserts in the following cycle, entering WADDR if the latched m_we=1, else RADDR.
REQ-019 SHALL, in WADDR, drive awvalid and wvalid together and drop each one independently on its own ready handshake.
- Handshakes may complete in the same or different cycles, in either order.
- WRESP is entered once both have completed.
REQ-020 SHALL, in WRESP, hold bready=1; on bvalid, capture err = bresp[1] and go to DONE.
REQ-021 SHALL, in RADDR, hold arvalid until arready, then go to RDATA.
REQ-022 SHALL, in RDATA, hold rready=1; on rvalid, capture rdata and err = rresp[1] and go to DONE.
REQ-023 SHALL, in DONE, pulse m_done[g] for one cycle, drop m_gnt, set ptr=(g+1) mod NM and return to IDLE.
REQ-024 SHALL keep all valid outputs stable until their handshake completes; an m_req drop after grant does not abort the transaction.
REQ-025 SHALL ignore requests that arrive outside IDLE until the FSM returns to IDLE.
- Minimum spacing is 1 idle cycle between transactions.
Reset
REQ-026 SHALL, when aresetn is low, immediately drive:
- awvalid, wvalid, arvalid, bready, rready, m_gnt, m_done and m_err to 0;
- awaddr, wrdata, araddr and m_rdata to 0.
REQ-027 SHALL, when aresetn is low, set the state to IDLE and ptr to 0, including mid-transaction; the aborted transaction is never reported as done.
Configuration
REQ-028 SHALL implement an optional timeout watchdog under macro PERIPHERAL_ARBITER_TIMEOUT_EN.
- When defined: an 8-bit counter clears on each state entry and increments in WADDR, WRESP, RADDR and RDATA. At 255, all valids and readies drop and DONE is entered with m_err=1 and m_rdata=0.
- When undefined: the FSM waits indefinitely and no counter exists.
Structure
REQ-029 SHALL place the FSM state enum, the response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the timeout limit in package peripheral_arbiter_apb4_pkg.
REQ-030 SHALL implement the round-robin selection (NM-bit request and pointer in, one-hot grant out) as sub-module peripheral_rr_arbiter_apb4.
Verification
REQ-031 SHALL cover: m0 write 0x10 <- 0xDEADBEEF, awready/wready at once, bresp=0 -> m_done[0] 3 cycles after grant, m_err=0.
REQ-032 SHALL cover: m0 and m1 requesting reads continuously -> grants alternate 0,1,0,1, with ptr wrapping after NM-1.
REQ-033 SHALL cover: wready 2 cycles before awready -> wvalid drops first, awvalid held, exactly one write reaches the slave.
REQ-034 SHALL cover: a read with rresp=2 and rdata=0x1234 -> m_err=1 and m_rdata=0x1234 with m_done.
REQ-035 SHALL cover: aresetn asserted in RDATA -> all outputs 0 at once, no m_done, next grant goes to m0.
REQ-036 SHALL cover: with PERIPHERAL_ARBITER_TIMEOUT_EN, arready held 0 -> DONE after 255 RADDR cycles with m_err=1.
